// File: rtl/ping_pong_stream_buffer_if.sv
// Stream-side bundle of the ping-pong buffer: write beat handshake with wide
// input bus and slice select, plus read word handshake with pass-end marker.
interface ping_pong_stream_buffer_if #(
  parameter int IN_WIDTH     = 512,
  parameter int MODULE_WIDTH = 128,
  parameter int SIDX_W       = 2
);
  logic [SIDX_W-1:0]       slicing_idx;
  logic                    wr_valid;
  logic                    wr_ready;
  logic [IN_WIDTH-1:0]     wr_data;
  logic                    rd_valid;
  logic                    rd_ready;
  logic [MODULE_WIDTH-1:0] rd_data;
  logic                    rd_last;

  // Buffer side
  modport slave (
    input  slicing_idx, wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data, rd_last
  );

  // Producer/consumer side
  modport master (
    output slicing_idx, wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/ping_pong_stream_buffer.sv
// Two-bank ping-pong buffer. The writer fills one bank with one selected
// slice per beat while the reader replays the other, oldest-first, a fixed
// number of passes before releasing it. Reads go through a 1-cycle RAM stage
// into a 2-entry skid so rd_data holds steady under back-pressure.
module ping_pong_stream_buffer #(
  parameter int WIDTH         = 16,
  parameter int CHUNK_SIZE    = 4,
  parameter int NUM_CORES_A   = 2,
  parameter int NUM_CORES_B   = 1,
  parameter int TOTAL_MODULES = 4,
  parameter int DEPTH         = 32,
  parameter int READ_PASSES   = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush_i,
  ping_pong_stream_buffer_if.slave        bus_io,
  output logic                            rd_bank_done_o,
  output logic [1:0]                      bank_full_o,
  output logic                            active_bank_wr_o,
  output logic                            active_bank_rd_o
);

  localparam int MW = WIDTH * CHUNK_SIZE * NUM_CORES_A * NUM_CORES_B;
  localparam int IW = MW * TOTAL_MODULES;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (READ_PASSES > 1) ? $clog2(READ_PASSES) : 1;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_e;

  bank_state_e bank_q [2];
  bank_state_e bank_d [2];

  logic          wr_bank_q, wr_bank_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [PW-1:0] pass_q, pass_d;
  logic          issue_done_q, issue_done_d;

  // RAM output stage sideband (data itself lives in ram_data_q)
  logic          ram_vld_q, ram_vld_d;
  logic          ram_last_q, ram_last_d;
  logic          ram_final_q, ram_final_d;
  logic [MW-1:0] ram_data_q;

  // Skid: entry 0 is the head presented on rd_data
  logic [MW-1:0] skid_data_q [2];
  logic [MW-1:0] skid_data_d [2];
  logic          skid_last_q [2];
  logic          skid_last_d [2];
  logic          skid_final_q [2];
  logic          skid_final_d [2];
  logic [1:0]    skid_cnt_q, skid_cnt_d;

  logic [MW-1:0] mem [2*DEPTH];
  logic [MW-1:0] slice [TOTAL_MODULES];
  logic [MW-1:0] wr_slice;

  logic          wr_ready;
  logic          wr_fire;
  logic          wr_wrap;
  logic          rd_pop;
  logic          rd_release;
  logic          rd_bank_busy;
  logic [1:0]    occ_after;
  logic          rd_issue;
  logic          rd_wrap;
  logic          rd_final_word;

  // Slice 0 is the most significant MODULE_WIDTH chunk of the wide bus
  generate
    for (genvar gi = 0; gi < TOTAL_MODULES; gi++) begin : g_slice
      assign slice[gi] = bus_io.wr_data[IW-(gi+1)*MW +: MW];
    end
  endgenerate

  assign wr_slice = slice[bus_io.slicing_idx];

  // Handshake qualifiers; flush overrides any same-cycle beat or pop
  assign wr_ready   = (bank_q[wr_bank_q] == BANK_EMPTY) || (bank_q[wr_bank_q] == BANK_FILLING);
  assign wr_fire    = bus_io.wr_valid && wr_ready && !flush_i;
  assign wr_wrap    = (wr_addr_q == AW'(DEPTH - 1));
  assign rd_pop     = (skid_cnt_q != 2'd0) && bus_io.rd_ready && !flush_i;
  assign rd_release = rd_pop && skid_final_q[0];

  // Issue only if the word in flight plus the skid leftover after this pop
  // still leaves a slot for the new word when it lands.
  assign rd_bank_busy  = (bank_q[rd_bank_q] == BANK_FULL) || (bank_q[rd_bank_q] == BANK_DRAINING);
  assign occ_after     = skid_cnt_q - 2'(rd_pop) + 2'(ram_vld_q);
  assign rd_issue      = rd_bank_busy && !issue_done_q && (occ_after < 2'd2) && !flush_i;
  assign rd_wrap       = (rd_addr_q == AW'(DEPTH - 1));
  assign rd_final_word = rd_wrap && (pass_q == PW'(READ_PASSES - 1));

  // Per-bank state next-state: writer and reader never own the same bank at once
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_d[b] = bank_q[b];
      if (wr_fire && (wr_bank_q == b[0])) begin
        bank_d[b] = wr_wrap ? BANK_FULL : BANK_FILLING;
      end
      if (rd_issue && (rd_bank_q == b[0]) && (bank_q[b] == BANK_FULL)) begin
        bank_d[b] = BANK_DRAINING;
      end
      if (rd_release && (rd_bank_q == b[0])) begin
        bank_d[b] = BANK_EMPTY;
      end
      if (flush_i) begin
        bank_d[b] = BANK_EMPTY;
      end
    end
  end

  // Write/read address, pass and bank-pointer next-state
  always_comb begin
    wr_addr_d    = wr_addr_q;
    wr_bank_d    = wr_bank_q;
    rd_addr_d    = rd_addr_q;
    rd_bank_d    = rd_bank_q;
    pass_d       = pass_q;
    issue_done_d = issue_done_q;
    if (wr_fire) begin
      wr_addr_d = wr_wrap ? '0 : wr_addr_q + AW'(1);
      if (wr_wrap) begin
        wr_bank_d = ~wr_bank_q;
      end
    end
    if (rd_issue) begin
      rd_addr_d = rd_wrap ? '0 : rd_addr_q + AW'(1);
      if (rd_wrap) begin
        pass_d = rd_final_word ? '0 : pass_q + PW'(1);
      end
      if (rd_final_word) begin
        issue_done_d = 1'b1;
      end
    end
    if (rd_release) begin
      issue_done_d = 1'b0;
      rd_bank_d    = ~rd_bank_q;
    end
    if (flush_i) begin
      wr_addr_d    = '0;
      wr_bank_d    = 1'b0;
      rd_addr_d    = '0;
      rd_bank_d    = 1'b0;
      pass_d       = '0;
      issue_done_d = 1'b0;
    end
  end

  // RAM stage sideband and skid shift/fill next-state
  always_comb begin
    ram_vld_d    = rd_issue;
    ram_last_d   = rd_wrap;
    ram_final_d  = rd_final_word;
    skid_cnt_d   = skid_cnt_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    skid_final_d = skid_final_q;
    if (rd_pop) begin
      skid_data_d[0]  = skid_data_q[1];
      skid_last_d[0]  = skid_last_q[1];
      skid_final_d[0] = skid_final_q[1];
      skid_cnt_d      = skid_cnt_q - 2'd1;
    end
    if (ram_vld_q) begin
      if (skid_cnt_d == 2'd0) begin
        skid_data_d[0]  = ram_data_q;
        skid_last_d[0]  = ram_last_q;
        skid_final_d[0] = ram_final_q;
      end else begin
        skid_data_d[1]  = ram_data_q;
        skid_last_d[1]  = ram_last_q;
        skid_final_d[1] = ram_final_q;
      end
      skid_cnt_d = skid_cnt_d + 2'd1;
    end
    if (flush_i) begin
      ram_vld_d  = 1'b0;
      skid_cnt_d = 2'd0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        bank_q[b]       <= BANK_EMPTY;
        skid_data_q[b]  <= '0;
        skid_last_q[b]  <= 1'b0;
        skid_final_q[b] <= 1'b0;
      end
      wr_bank_q    <= 1'b0;
      wr_addr_q    <= '0;
      rd_bank_q    <= 1'b0;
      rd_addr_q    <= '0;
      pass_q       <= '0;
      issue_done_q <= 1'b0;
      ram_vld_q    <= 1'b0;
      ram_last_q   <= 1'b0;
      ram_final_q  <= 1'b0;
      skid_cnt_q   <= 2'd0;
    end else begin
      bank_q       <= bank_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      skid_final_q <= skid_final_d;
      wr_bank_q    <= wr_bank_d;
      wr_addr_q    <= wr_addr_d;
      rd_bank_q    <= rd_bank_d;
      rd_addr_q    <= rd_addr_d;
      pass_q       <= pass_d;
      issue_done_q <= issue_done_d;
      ram_vld_q    <= ram_vld_d;
      ram_last_q   <= ram_last_d;
      ram_final_q  <= ram_final_d;
      skid_cnt_q   <= skid_cnt_d;
    end
  end

  // Dual-port RAM: port A writes, port B registered read; bank is the address MSB
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[{wr_bank_q, wr_addr_q}] <= wr_slice;
    end
    if (rd_issue) begin
      ram_data_q <= mem[{rd_bank_q, rd_addr_q}];
    end
  end

  assign bus_io.wr_ready = wr_ready;
  assign bus_io.rd_valid = (skid_cnt_q != 2'd0);
  assign bus_io.rd_data  = skid_data_q[0];
  assign bus_io.rd_last  = (skid_cnt_q != 2'd0) && skid_last_q[0];
  assign rd_bank_done_o  = rd_release;
  assign active_bank_wr_o = wr_bank_q;
  assign active_bank_rd_o = rd_bank_q;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_full
      assign bank_full_o[gi] = (bank_q[gi] == BANK_FULL) || (bank_q[gi] == BANK_DRAINING);
    end
  endgenerate

endmodule

// File: tb/tb_ping_pong_stream_buffer.sv
// Bench for ping_pong_stream_buffer: directed scenarios plus random traffic,
// all checked each cycle against a bank-level reference model.
module tb_ping_pong_stream_buffer;
  localparam int WIDTH = 8, CHUNK = 2, NCA = 1, NCB = 1, TM = 4;
  localparam int DEPTH = 4, RP = 2;
  localparam int MW = WIDTH * CHUNK * NCA * NCB;
  localparam int IW = MW * TM;
  localparam int SW = $clog2(TM);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic rd_bank_done;
  logic [1:0] bank_full;
  logic act_wr, act_rd;

  ping_pong_stream_buffer_if #(.IN_WIDTH(IW), .MODULE_WIDTH(MW), .SIDX_W(SW)) bus ();

  ping_pong_stream_buffer #(
    .WIDTH(WIDTH), .CHUNK_SIZE(CHUNK), .NUM_CORES_A(NCA), .NUM_CORES_B(NCB),
    .TOTAL_MODULES(TM), .DEPTH(DEPTH), .READ_PASSES(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .bus_io(bus),
    .rd_bank_done_o(rd_bank_done), .bank_full_o(bank_full),
    .active_bank_wr_o(act_wr), .active_bank_rd_o(act_rd)
  );

  always #5 clk = ~clk;

  // Reference model: words expected on the read side in order
  typedef struct packed {
    logic [MW-1:0] d;
    logic          last;
    logic          fin;
  } exp_t;

  exp_t          exp_q[$];
  logic [MW-1:0] fill_buf[$];
  int            w_cnt, rel_cnt;
  logic          prev_stall;
  logic [MW-1:0] prev_data;
  logic          prev_last;
  int            n_assert = 0, n_fail = 0;
  int            done_seen, last_seen;
  logic          last_wr_fire;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    fill_buf.delete();
    w_cnt = 0;
    rel_cnt = 0;
    prev_stall = 1'b0;
  endtask

  function automatic logic [1:0] model_full();
    logic [1:0] f;
    int c;
    f = 2'b00;
    c = w_cnt / DEPTH;
    if (rel_cnt < c)     f[rel_cnt % 2] = 1'b1;
    if (rel_cnt + 1 < c) f[(rel_cnt + 1) % 2] = 1'b1;
    return f;
  endfunction

  // Check one cycle at the current (negedge) time, advance the model by the
  // handshakes that the coming rising edge will perform, then wait a cycle.
  task automatic tick();
    logic wr_fire, rd_fire, rel;
    logic [63:0] shifted;
    exp_t e;
    #1;
    rel = 1'b0;
    chk("wr_ready", 64'(bus.wr_ready), 64'((w_cnt / DEPTH) <= rel_cnt + 1));
    chk("active_bank_wr", 64'(act_wr), 64'((w_cnt / DEPTH) % 2));
    chk("active_bank_rd", 64'(act_rd), 64'(rel_cnt % 2));
    chk("bank_full", 64'(bank_full), 64'(model_full()));
    if (exp_q.size() == 0) chk("rd_valid_idle", 64'(bus.rd_valid), 64'd0);
    if (prev_stall) begin
      chk("stall_valid", 64'(bus.rd_valid), 64'd1);
      chk("stall_data", 64'(bus.rd_data), 64'(prev_data));
      chk("stall_last", 64'(bus.rd_last), 64'(prev_last));
    end
    wr_fire = bus.wr_valid && bus.wr_ready && !flush && rst_n;
    rd_fire = bus.rd_valid && bus.rd_ready && !flush && rst_n;
    last_wr_fire = wr_fire;
    if (rd_bank_done) done_seen++;
    if (rd_fire && bus.rd_last) last_seen++;
    if (rd_fire && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rd_data", 64'(bus.rd_data), 64'(e.d));
      chk("rd_last", 64'(bus.rd_last), 64'(e.last));
      chk("rd_bank_done", 64'(rd_bank_done), 64'(e.fin));
      rel = e.fin;
    end else begin
      chk("rd_bank_done_idle", 64'(rd_bank_done), 64'd0);
    end
    if (wr_fire) begin
      shifted = 64'(bus.wr_data) >> ((TM - 1 - int'(bus.slicing_idx)) * MW);
      fill_buf.push_back(MW'(shifted));
      w_cnt++;
      if (fill_buf.size() == DEPTH) begin
        for (int p = 0; p < RP; p++) begin
          for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back('{d: fill_buf[i], last: (i == DEPTH - 1),
                              fin: (i == DEPTH - 1) && (p == RP - 1)});
          end
        end
        fill_buf.delete();
      end
    end
    if (rel) rel_cnt++;
    prev_stall = bus.rd_valid && !bus.rd_ready && rst_n;
    prev_data  = bus.rd_data;
    prev_last  = bus.rd_last;
    if (flush || !rst_n) model_clear();
    @(negedge clk);
  endtask

  // Present one beat carrying val in slice sidx (other slices random); hold
  // it until accepted, within a cycle budget.
  task automatic wr_beat(input logic [MW-1:0] val, input int sidx);
    logic [63:0] d, mask;
    int sh;
    bit ok;
    mask = (64'd1 << MW) - 64'd1;
    sh = (TM - 1 - sidx) * MW;
    d = {$urandom(), $urandom()};
    d = (d & ~(mask << sh)) | (64'(val) << sh);
    bus.wr_data = IW'(d);
    bus.slicing_idx = SW'(sidx);
    bus.wr_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (last_wr_fire) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("wr_beat_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && !bus.rd_valid) break;
      tick();
    end
    chk("drain_complete", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int lat;
    bus.wr_valid = 1'b0;
    bus.wr_data = '0;
    bus.slicing_idx = '0;
    bus.rd_ready = 1'b0;
    model_clear();
    done_seen = 0;
    last_seen = 0;
    @(negedge clk);
    tick();
    chk("reset_wr_ready", 64'(bus.wr_ready), 64'd1);
    chk("reset_rd_valid", 64'(bus.rd_valid), 64'd0);
    rst_n = 1'b1;
    tick();

    // Slice 1 carries 1..4, one bank, reader always ready
    bus.rd_ready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) wr_beat(MW'(i), 1);
    bus.wr_valid = 1'b0;
    lat = 10;
    for (int n = 0; n < 10; n++) begin
      if (bus.rd_valid) begin
        lat = n;
        break;
      end
      tick();
    end
    chk("first_word_latency", 64'(lat), 64'd2);
    chk("first_word", 64'(bus.rd_data), 64'd1);
    done_seen = 0;
    last_seen = 0;
    drain();
    chk("bank_done_count", 64'(done_seen), 64'd1);
    chk("rd_last_count", 64'(last_seen), 64'(RP));

    // Writer outruns a stalled reader: both banks fill, then back-pressure
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 2 * DEPTH; i++) wr_beat(MW'($urandom()), int'($urandom_range(0, TM - 1)));
    chk("both_full", 64'(bank_full), 64'd3);
    chk("wr_blocked", 64'(bus.wr_ready), 64'd0);
    for (int i = 0; i < 3; i++) tick();
    bus.rd_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) wr_beat(MW'($urandom()), int'($urandom_range(0, TM - 1)));
    drain();

    // Async reset mid-fill, then a clean fill must start at bank 0 addr 0
    for (int i = 0; i < 2; i++) wr_beat(MW'(16'hA0 + i), 0);
    bus.wr_valid = 1'b0;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("async_rst_wr_ready", 64'(bus.wr_ready), 64'd1);
    chk("async_rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("async_rst_bank_full", 64'(bank_full), 64'd0);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) wr_beat(MW'(16'hB0 + i), 3);
    drain();

    // Flush mid-drain
    for (int i = 0; i < DEPTH; i++) wr_beat(MW'(16'hC0 + i), 2);
    bus.wr_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("flush_bank_full", 64'(bank_full), 64'd0);
    chk("flush_act_wr", 64'(act_wr), 64'd0);
    tick();

    // Continuous streaming, 8 banks, reader always ready
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 8 * DEPTH; i++) wr_beat(MW'(i * 7 + 3), int'($urandom_range(0, TM - 1)));
    drain();

    // Random traffic with random back-pressure
    for (int i = 0; i < 600; i++) begin
      bus.wr_valid = ($urandom_range(0, 3) != 0);
      bus.wr_data = IW'({$urandom(), $urandom()});
      bus.slicing_idx = SW'($urandom_range(0, TM - 1));
      bus.rd_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
